// File: rtl/column_buffer_scheduler_pkg.sv
// Shared types and constants for the column buffer scheduler: column word,
// buffer index, the column assembly state machine and the status helper.
package column_pkg;

    localparam int NUM_COLS   = 640;
    localparam int AV_DATA_W  = 16;
    localparam int COL_ADDR_W = 10;

    typedef logic [27:0] col_word_t;
    typedef logic [1:0]  buf_idx_t;

    typedef enum logic [1:0] {
        HALF0  = 2'd0,
        HALF1  = 2'd1,
        COMMIT = 2'd2
    } col_state_t;

    // Status reports the overrun count in four bits, pinned at 15 once it grows past.
    function automatic logic [3:0] sat_nibble(input logic [7:0] value);
        return (value > 8'd15) ? 4'hF : value[3:0];
    endfunction

endpackage

// File: rtl/column_buffer_scheduler_if.sv
// Avalon-MM slave bus carrying column data and control/status accesses.
interface column_buffer_scheduler_if;
    import column_pkg::*;

    logic                 chipselect;
    logic                 write;
    logic                 read;
    logic                 address;
    logic [AV_DATA_W-1:0] writedata;
    logic [AV_DATA_W-1:0] readdata;
    logic                 waitrequest;

    modport master (
        output chipselect, write, read, address, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  chipselect, write, read, address, writedata,
        output readdata, waitrequest
    );

endinterface

// File: rtl/column_buffer_scheduler_rotator.sv
// Triple-buffer index rotation: tracks which buffer is scanned out, which is
// being filled and which holds a finished frame waiting for vertical blank.
module buffer_index_rotator
    import column_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       commit,
    input  logic       frame_start,
    input  logic       clear_overrun,
    output buf_idx_t   rd_idx,
    output buf_idx_t   wr_idx,
    output logic       pending,
    output logic [7:0] overrun
);

    buf_idx_t spare_idx;

    // A commit landing in vertical blank goes straight to scan-out, so the
    // spare keeps its slot and the old display buffer becomes the fill target.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_idx    <= buf_idx_t'(0);
            wr_idx    <= buf_idx_t'(1);
            spare_idx <= buf_idx_t'(2);
            pending   <= 1'b0;
            overrun   <= 8'd0;
        end else begin
            if (commit && frame_start) begin
                rd_idx  <= wr_idx;
                wr_idx  <= rd_idx;
                pending <= 1'b0;
            end else if (commit) begin
                wr_idx    <= spare_idx;
                spare_idx <= wr_idx;
                pending   <= 1'b1;
            end else if (frame_start && pending) begin
                rd_idx    <= spare_idx;
                spare_idx <= rd_idx;
                pending   <= 1'b0;
            end

            if (clear_overrun) begin
                overrun <= 8'd0;
            end else if (commit && !frame_start && pending && overrun != 8'hFF) begin
                overrun <= overrun + 8'd1;
            end
        end
    end

endmodule

// File: rtl/column_buffer_scheduler.sv
// Assembles 28-bit column words from pairs of 16-bit Avalon writes, streams them
// to the column store and hands completed frames to the triple-buffer rotator.
module column_buffer_scheduler #(
    parameter int NUM_COLS = column_pkg::NUM_COLS
) (
    input  logic                              clk,
    input  logic                              reset_n,
    column_buffer_scheduler_if.slave          bus,
    input  logic                              frame_start,
    output logic                              col_we,
    output logic [column_pkg::COL_ADDR_W-1:0] col_wr_addr,
    output column_pkg::col_word_t             col_wr_data,
    output column_pkg::buf_idx_t              wr_buf_idx,
    output column_pkg::buf_idx_t              rd_buf_idx
);
    import column_pkg::*;

    col_state_t            state;
    col_state_t            state_next;
    logic [COL_ADDR_W-1:0] counter;
    logic [12:0]           hi13;
    logic                  accepted;
    logic                  data_wr;
    logic                  ctrl_wr;
    logic                  soft_restart;
    logic                  last_col;
    logic                  commit;
    logic                  pending;
    logic [7:0]            overrun;
    logic                  unused_writedata_msb;

    assign commit       = (state == COMMIT);
    assign accepted     = bus.chipselect & bus.write & ~bus.waitrequest;
    assign data_wr      = accepted & ~bus.address;
    assign ctrl_wr      = accepted & bus.address;
    assign soft_restart = ctrl_wr & bus.writedata[0];
    assign last_col     = (counter == COL_ADDR_W'(NUM_COLS - 1));

    assign bus.waitrequest = commit;
    assign bus.readdata    = (bus.chipselect && bus.read && bus.address)
                           ? {pending, (state == HALF1), sat_nibble(overrun), counter}
                           : '0;

    assign unused_writedata_msb = bus.writedata[15];

    // State register for the column assembly sequence.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= HALF0;
        end else begin
            state <= state_next;
        end
    end

    // Soft restart abandons a half-assembled column; COMMIT is a single stall cycle.
    always_comb begin
        state_next = state;
        if (soft_restart) begin
            state_next = HALF0;
        end else begin
            case (state)
                HALF0:   if (data_wr) state_next = HALF1;
                HALF1:   if (data_wr) state_next = last_col ? COMMIT : HALF0;
                COMMIT:  state_next = HALF0;
                default: state_next = HALF0;
            endcase
        end
    end

    // The column word and its address are registered so col_we is a clean
    // one-cycle pulse in the cycle after the second half is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter     <= '0;
            hi13        <= '0;
            col_we      <= 1'b0;
            col_wr_addr <= '0;
            col_wr_data <= '0;
        end else begin
            col_we <= 1'b0;
            if (soft_restart) begin
                counter <= '0;
            end else if (data_wr && state == HALF0) begin
                hi13 <= bus.writedata[12:0];
            end else if (data_wr && state == HALF1) begin
                col_we      <= 1'b1;
                col_wr_addr <= counter;
                col_wr_data <= {hi13, bus.writedata[14:0]};
                counter     <= last_col ? '0 : counter + COL_ADDR_W'(1);
            end
        end
    end

    buffer_index_rotator u_rotator (
        .clk           (clk),
        .reset_n       (reset_n),
        .commit        (commit),
        .frame_start   (frame_start),
        .clear_overrun (ctrl_wr & bus.writedata[1]),
        .rd_idx        (rd_buf_idx),
        .wr_idx        (wr_buf_idx),
        .pending       (pending),
        .overrun       (overrun)
    );

endmodule

// File: tb/tb_column_buffer_scheduler.sv
// Self-checking bench: a transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_column_buffer_scheduler;
    import column_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  frame_start;
    logic                  col_we;
    logic [COL_ADDR_W-1:0] col_wr_addr;
    col_word_t             col_wr_data;
    buf_idx_t              wr_buf_idx;
    buf_idx_t              rd_buf_idx;

    column_buffer_scheduler_if bus ();

    column_buffer_scheduler #(.NUM_COLS(640)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .frame_start (frame_start),
        .col_we      (col_we),
        .col_wr_addr (col_wr_addr),
        .col_wr_data (col_wr_data),
        .wr_buf_idx  (wr_buf_idx),
        .rd_buf_idx  (rd_buf_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit armed = 1'b0;

    // Observations of the DUT gathered by the per-cycle checker.
    int        weCount = 0;
    int        commitCount = 0;
    int        stalls = 0;
    int        lastAddr = 0;
    col_word_t lastData = '0;

    // Reference model: words received so far, what should reach the column
    // store, and the three buffer roles.
    bit          mWe, mCommit, mPending;
    int          mHalf, mCol, mAddr, mRd, mWr, mSpare, mOverrun;
    logic [12:0] mHi;
    col_word_t   mData;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        bit commitNow;
        bit accepted;
        int t;
        if (!reset_n) begin
            mWe = 0; mCommit = 0; mPending = 0; mHalf = 0; mCol = 0;
            mAddr = 0; mData = '0; mHi = '0; mOverrun = 0;
            mRd = 0; mWr = 1; mSpare = 2;
        end else begin
            commitNow = mCommit;
            accepted  = bus.chipselect && bus.write && !mCommit;
            mWe = 0;
            mCommit = 0;
            if (commitNow && frame_start) begin
                t = mRd; mRd = mWr; mWr = t; mPending = 0;
            end else if (commitNow) begin
                t = mWr; mWr = mSpare; mSpare = t;
                if (mPending && mOverrun < 255) mOverrun++;
                mPending = 1;
            end else if (frame_start && mPending) begin
                t = mRd; mRd = mSpare; mSpare = t; mPending = 0;
            end
            if (accepted && bus.address) begin
                if (bus.writedata[1]) mOverrun = 0;
                if (bus.writedata[0]) begin mCol = 0; mHalf = 0; end
            end else if (accepted) begin
                if (mHalf == 0) begin
                    mHi = bus.writedata[12:0];
                    mHalf = 1;
                end else begin
                    mWe = 1;
                    mAddr = mCol;
                    mData = {mHi, bus.writedata[14:0]};
                    mHalf = 0;
                    if (mCol == 639) begin mCol = 0; mCommit = 1; end
                    else mCol++;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (armed && reset_n) begin
            checkOutput("col_we", 32'(col_we), 32'(mWe));
            if (mWe) begin
                checkOutput("col_wr_addr", 32'(col_wr_addr), 32'(mAddr));
                checkOutput("col_wr_data", 32'(col_wr_data), 32'(mData));
            end
            checkOutput("waitrequest", 32'(bus.waitrequest), 32'(mCommit));
            checkOutput("wr_buf_idx", 32'(wr_buf_idx), 32'(mWr));
            checkOutput("rd_buf_idx", 32'(rd_buf_idx), 32'(mRd));
            if (col_we) begin
                weCount++;
                lastAddr = int'(col_wr_addr);
                lastData = col_wr_data;
            end
            if (bus.waitrequest) commitCount++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic busWrite(input logic a, input logic [15:0] d);
        int guard = 0;
        @(negedge clk);
        bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = d;
        #1;
        while (bus.waitrequest && guard < 8) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 8) checkOutput("write_stall_bound", 32'(guard), 32'd0);
        if (guard > 0) stalls++;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0; bus.write = 1'b0;
    endtask

    task automatic checkRead(input string name, input logic a, input logic [15:0] exp);
        @(negedge clk);
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = a;
        #1;
        checkOutput(name, 32'(bus.readdata), 32'(exp));
        bus.chipselect = 1'b0; bus.read = 1'b0;
    endtask

    task automatic writeColumns(input int first, input int n);
        for (int c = first; c < first + n; c++) begin
            busWrite(1'b0, 16'hE000 | 16'(c));
            busWrite(1'b0, 16'(c) ^ 16'hC35A);
        end
    endtask

    task automatic pulseFrameStart();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic doReset(input bit immediate);
        if (!immediate) @(posedge clk);
        #2;
        if (immediate) checkOutput("pre_reset_col_we", 32'(col_we), 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("rst_col_we", 32'(col_we), 32'd0);
        checkOutput("rst_col_wr_addr", 32'(col_wr_addr), 32'd0);
        checkOutput("rst_col_wr_data", 32'(col_wr_data), 32'd0);
        checkOutput("rst_rd_idx", 32'(rd_buf_idx), 32'd0);
        checkOutput("rst_wr_idx", 32'(wr_buf_idx), 32'd1);
        checkOutput("rst_waitrequest", 32'(bus.waitrequest), 32'd0);
        bus.chipselect = 1'b1; bus.read = 1'b1; bus.address = 1'b1;
        #1;
        checkOutput("rst_status", 32'(bus.readdata), 32'd0);
        bus.chipselect = 1'b0; bus.read = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic applyStimulus();
        int w0, cb, st;

        // Single column pair: upper 13 bits from the first word, lower 15 from the second.
        w0 = weCount;
        busWrite(1'b0, 16'h1ABC);
        checkRead("status_half1", 1'b1, 16'h4000);
        busWrite(1'b0, 16'h7123);
        idle(2);
        checkOutput("pair_pulses", 32'(weCount - w0), 32'd1);
        checkOutput("pair_addr", 32'(lastAddr), 32'd0);
        checkOutput("pair_data", 32'(lastData), 32'h0D5E7123);
        checkRead("status_one_col", 1'b1, 16'h0001);
        checkRead("addr0_read_zero", 1'b0, 16'h0000);

        // Finish the first frame, then hand it to scan-out in vertical blank.
        cb = commitCount;
        writeColumns(1, 639);
        checkOutput("commit_waitrequest", 32'(bus.waitrequest), 32'd1);
        idle(2);
        checkOutput("commit_cycles", 32'(commitCount - cb), 32'd1);
        checkOutput("frame_pulses", 32'(weCount - w0), 32'd640);
        checkOutput("frame_wr_idx", 32'(wr_buf_idx), 32'd2);
        checkOutput("frame_rd_idx", 32'(rd_buf_idx), 32'd0);
        checkRead("status_pending", 1'b1, 16'h8000);
        pulseFrameStart();
        checkOutput("swap_rd_idx", 32'(rd_buf_idx), 32'd1);
        checkOutput("swap_wr_idx", 32'(wr_buf_idx), 32'd2);
        checkRead("status_after_swap", 1'b1, 16'h0000);

        // Two frames with no vertical blank: one overrun, second frame stalls once.
        st = stalls;
        writeColumns(0, 640);
        writeColumns(0, 640);
        idle(3);
        checkOutput("overrun_stalls", 32'(stalls - st), 32'd1);
        checkOutput("overrun_rd_idx", 32'(rd_buf_idx), 32'd1);
        checkOutput("overrun_wr_idx", 32'(wr_buf_idx), 32'd2);
        checkRead("status_overrun", 1'b1, 16'h8400);
        busWrite(1'b1, 16'h0002);
        checkRead("status_overrun_clr", 1'b1, 16'h8000);
        pulseFrameStart();
        checkOutput("overrun_swap_rd", 32'(rd_buf_idx), 32'd0);
        checkOutput("overrun_swap_wr", 32'(wr_buf_idx), 32'd2);

        // Vertical blank arriving in the commit cycle itself.
        doReset(1'b0);
        cb = commitCount;
        writeColumns(0, 640);
        pulseFrameStart();
        idle(2);
        checkOutput("coincide_commits", 32'(commitCount - cb), 32'd1);
        checkOutput("coincide_rd_idx", 32'(rd_buf_idx), 32'd1);
        checkOutput("coincide_wr_idx", 32'(wr_buf_idx), 32'd0);
        checkRead("coincide_status", 1'b1, 16'h0000);

        // Soft restart mid-frame and mid-column, then a clean full frame.
        writeColumns(0, 300);
        checkRead("status_300", 1'b1, 16'h012C);
        busWrite(1'b0, 16'h1234);
        checkRead("status_300_half", 1'b1, 16'h412C);
        busWrite(1'b1, 16'h0001);
        checkRead("status_restart", 1'b1, 16'h0000);
        w0 = weCount;
        cb = commitCount;
        writeColumns(0, 640);
        idle(3);
        checkOutput("restart_pulses", 32'(weCount - w0), 32'd640);
        checkOutput("restart_last_addr", 32'(lastAddr), 32'd639);
        checkOutput("restart_commits", 32'(commitCount - cb), 32'd1);
        checkOutput("restart_wr_idx", 32'(wr_buf_idx), 32'd2);
        checkOutput("restart_rd_idx", 32'(rd_buf_idx), 32'd1);
        checkRead("status_restart_frame", 1'b1, 16'h8000);

        // Reset while a column pulse is live, and again with a half word latched.
        busWrite(1'b0, 16'h5555);
        busWrite(1'b0, 16'h2222);
        doReset(1'b1);
        busWrite(1'b0, 16'h7777);
        doReset(1'b0);
        w0 = weCount;
        busWrite(1'b0, 16'hF0FF);
        idle(2);
        checkOutput("no_pulse_after_reset", 32'(weCount - w0), 32'd0);
        busWrite(1'b0, 16'h8001);
        idle(2);
        checkOutput("post_reset_pulses", 32'(weCount - w0), 32'd1);
        checkOutput("post_reset_addr", 32'(lastAddr), 32'd0);
        checkOutput("post_reset_data", 32'(lastData), 32'h087F8001);
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        reset_n        = 1'b0;
        frame_start    = 1'b0;
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.read       = 1'b0;
        bus.address    = 1'b0;
        bus.writedata  = 16'h0000;
        idle(2);
        reset_n = 1'b1;
        armed   = 1'b1;
        #1;
        checkOutput("init_col_we", 32'(col_we), 32'd0);
        checkOutput("init_rd_idx", 32'(rd_buf_idx), 32'd0);
        checkOutput("init_wr_idx", 32'(wr_buf_idx), 32'd1);
        checkRead("init_status", 1'b1, 16'h0000);
        applyStimulus();
        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
